// File: rtl/branch_queue_ctrl_if.sv
// Bundle between decode, the branch queue controller, the branch unit and fetch.
// Signal names keep the controller's point of view (i_ = into the controller).
interface branch_queue_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    // Decode enqueue channel
    logic             i_enq_valid;
    logic             o_enq_ready;
    logic [2:0]       i_enq_op;
    logic [WIDTH-1:0] i_enq_op1;
    logic [WIDTH-1:0] i_enq_op2;
    logic             i_enq_pred;
    logic [WIDTH-1:0] i_enq_pc;
    logic [WIDTH-1:0] i_enq_target;

    // Branch unit issue/result channel
    logic [2:0]       o_bu_op;
    logic [WIDTH-1:0] o_bu_op1;
    logic [WIDTH-1:0] o_bu_op2;
    logic             o_bu_pred;
    logic             o_bu_start;
    logic             i_bu_taken;
    logic             i_bu_flush;
    logic             i_bu_valid;

    // Resolution record towards fetch
    logic             o_res_valid;
    logic             o_res_taken;
    logic             o_res_mispredict;
    logic [WIDTH-1:0] o_redirect_pc;
    logic             o_flush;

    modport slave (
        input  i_enq_valid, i_enq_op, i_enq_op1, i_enq_op2, i_enq_pred, i_enq_pc, i_enq_target,
        input  i_bu_taken, i_bu_flush, i_bu_valid,
        output o_enq_ready,
        output o_bu_op, o_bu_op1, o_bu_op2, o_bu_pred, o_bu_start,
        output o_res_valid, o_res_taken, o_res_mispredict, o_redirect_pc, o_flush
    );

    modport master (
        output i_enq_valid, i_enq_op, i_enq_op1, i_enq_op2, i_enq_pred, i_enq_pc, i_enq_target,
        output i_bu_taken, i_bu_flush, i_bu_valid,
        input  o_enq_ready,
        input  o_bu_op, o_bu_op1, o_bu_op2, o_bu_pred, o_bu_start,
        input  o_res_valid, o_res_taken, o_res_mispredict, o_redirect_pc, o_flush
    );
endinterface

// File: rtl/branch_queue_ctrl.sv
// In-order branch resolution controller: queues predicted branches, issues them one at a
// time to the shared branch unit and registers a resolution/redirect record for fetch.
// A mispredict discards every younger queued branch since they are on the wrong path.
module branch_queue_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    branch_queue_ctrl_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e              state_q, state_d;
    logic [PtrW-1:0]     head_q, head_d;
    logic [PtrW-1:0]     tail_q, tail_d;
    logic [CntW-1:0]     count_q, count_d;

    logic                res_valid_q, res_valid_d;
    logic                res_taken_q, res_taken_d;
    logic                res_mispredict_q, res_mispredict_d;
    logic [WIDTH-1:0]    redirect_q, redirect_d;
    logic                flush_q, flush_d;

    logic [2:0]          op_mem     [DEPTH];
    logic [WIDTH-1:0]    op1_mem    [DEPTH];
    logic [WIDTH-1:0]    op2_mem    [DEPTH];
    logic                pred_mem   [DEPTH];
    logic [WIDTH-1:0]    pc_mem     [DEPTH];
    logic [WIDTH-1:0]    target_mem [DEPTH];

    logic enq_ready;
    logic enq_fire;
    logic pop;
    logic mispred;

    // Space is judged on the registered count only; a same-cycle pop does not free a slot.
    assign enq_ready = (count_q != CntW'(DEPTH));
    assign pop       = (state_q == StWait) && bus.i_bu_valid;
    assign mispred   = pop && bus.i_bu_flush;
    assign enq_fire  = bus.i_enq_valid && enq_ready && !i_flush && !mispred;

    // Queue storage; written at tail on an accepted enqueue, no reset needed.
    always_ff @(posedge i_clk) begin
        if (enq_fire) begin
            op_mem[tail_q]     <= bus.i_enq_op;
            op1_mem[tail_q]    <= bus.i_enq_op1;
            op2_mem[tail_q]    <= bus.i_enq_op2;
            pred_mem[tail_q]   <= bus.i_enq_pred;
            pc_mem[tail_q]     <= bus.i_enq_pc;
            target_mem[tail_q] <= bus.i_enq_target;
        end
    end

    // Pointer and occupancy update; a kill of either kind empties the queue.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (i_flush || mispred) begin
            head_d  = tail_q;
            count_d = '0;
        end else begin
            if (enq_fire) tail_d = tail_q + PtrW'(1);
            if (pop)      head_d = head_q + PtrW'(1);
            count_d = count_q + CntW'(enq_fire) - CntW'(pop);
        end
    end

    // Issue FSM next state; external flush always returns to idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != '0) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait: begin
                if (bus.i_bu_valid) begin
                    if (bus.i_bu_flush)       state_d = StIdle;
                    else if (count_d != '0)   state_d = StIssue;
                    else                      state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (i_flush) state_d = StIdle;
    end

    // Resolution record; direction fields hold until the next resolution.
    always_comb begin
        res_valid_d      = pop && !i_flush;
        flush_d          = mispred && !i_flush;
        res_taken_d      = res_taken_q;
        res_mispredict_d = res_mispredict_q;
        redirect_d       = redirect_q;
        if (res_valid_d) begin
            res_taken_d      = bus.i_bu_taken;
            res_mispredict_d = bus.i_bu_flush;
            redirect_d       = bus.i_bu_taken ? target_mem[head_q] : pc_mem[head_q] + WIDTH'(4);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q          <= StIdle;
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_mispredict_q <= 1'b0;
            redirect_q       <= '0;
            flush_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_mispredict_q <= res_mispredict_d;
            redirect_q       <= redirect_d;
            flush_q          <= flush_d;
        end
    end

    assign bus.o_enq_ready      = enq_ready;
    assign bus.o_bu_op          = op_mem[head_q];
    assign bus.o_bu_op1         = op1_mem[head_q];
    assign bus.o_bu_op2         = op2_mem[head_q];
    assign bus.o_bu_pred        = pred_mem[head_q];
    assign bus.o_bu_start       = (state_q == StIssue);
    assign bus.o_res_valid      = res_valid_q;
    assign bus.o_res_taken      = res_taken_q;
    assign bus.o_res_mispredict = res_mispredict_q;
    assign bus.o_redirect_pc    = redirect_q;
    assign bus.o_flush          = flush_q;
endmodule

// File: tb/tb_branch_queue_ctrl.sv
// Bench for branch_queue_ctrl: plays decode and the branch unit, keeps a queue-of-branches
// reference model and checks every output each cycle plus directed latency scenarios.
module tb_branch_queue_ctrl;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        pred;
        logic [31:0] pc;
        logic [31:0] target;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n;
    logic ext_flush;

    branch_queue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    branch_queue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_flush (ext_flush),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t        mq[$];
    bit          outstanding;
    int          bu_dly;
    int          extra;
    bit          rnd_dly;
    int          cyc;
    int          stall;
    logic        exp_rv, exp_fl, exp_tk, exp_mp;
    logic [31:0] exp_rd;
    int          starts_q[$];
    int          nres_dut;
    int          total;
    int          bad;

    function automatic bit br_taken(ent_t e);
        bit b;
        if (e.op[2]) b = e.op[1] ? (e.op1 < e.op2) : ($signed(e.op1) < $signed(e.op2));
        else         b = (e.op1 == e.op2);
        return b ^ e.op[0];
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.op     = 3'($urandom_range(7));
        e.op1    = ($urandom_range(1) == 0) ? 32'($urandom_range(3)) : 32'($urandom);
        e.op2    = ($urandom_range(1) == 0) ? 32'($urandom_range(3)) : 32'($urandom);
        e.pred   = 1'($urandom_range(1));
        e.pc     = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : 32'($urandom);
        e.target = 32'($urandom);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0b want %0b", tag, obs, exp);
        end
    endtask

    // One clock: drive decode/branch-unit inputs, advance the model, check outputs.
    task automatic cycle(input bit en, input ent_t e, input bit fl, input bit rst, output bit acc);
        bit   vld, tk, bf, rdy, pop, mis;
        ent_t h;
        vld = 1'b0;
        tk  = 1'($urandom_range(1));
        bf  = 1'($urandom_range(1));
        if (outstanding && mq.size() > 0) begin
            if (bu_dly == 0) begin
                h   = mq[0];
                vld = 1'b1;
                tk  = br_taken(h);
                bf  = (tk != h.pred);
            end else begin
                bu_dly--;
            end
        end
        rst_n            = !rst;
        ext_flush        = fl;
        bus.i_enq_valid  = en;
        bus.i_enq_op     = e.op;
        bus.i_enq_op1    = e.op1;
        bus.i_enq_op2    = e.op2;
        bus.i_enq_pred   = e.pred;
        bus.i_enq_pc     = e.pc;
        bus.i_enq_target = e.target;
        bus.i_bu_valid   = vld;
        bus.i_bu_taken   = tk;
        bus.i_bu_flush   = bf;
        rdy = (mq.size() < DEPTH);
        pop = vld && !rst;
        mis = pop && bf && !fl;
        acc = 1'b0;

        @(posedge clk);
        #1;
        cyc++;

        if (rst) begin
            mq.delete();
            outstanding = 1'b0;
            exp_rv = 1'b0; exp_fl = 1'b0; exp_tk = 1'b0; exp_mp = 1'b0; exp_rd = '0;
        end else if (fl) begin
            mq.delete();
            outstanding = 1'b0;
            exp_rv = 1'b0; exp_fl = 1'b0;
        end else begin
            exp_rv = pop;
            exp_fl = mis;
            if (pop) begin
                h           = mq.pop_front();
                exp_tk      = tk;
                exp_mp      = bf;
                exp_rd      = tk ? h.target : h.pc + 32'd4;
                outstanding = 1'b0;
            end
            if (mis) mq.delete();
            else if (en && rdy) begin
                mq.push_back(e);
                acc = 1'b1;
            end
        end

        chk1("enq_ready", bus.o_enq_ready, mq.size() < DEPTH);
        chk1("res_valid", bus.o_res_valid, exp_rv);
        chk1("res_flush", bus.o_flush, exp_fl);
        chk1("res_taken", bus.o_res_taken, exp_tk);
        chk1("res_mispredict", bus.o_res_mispredict, exp_mp);
        chk("redirect_pc", bus.o_redirect_pc, exp_rd);
        if (bus.o_res_valid) nres_dut++;

        if (bus.o_bu_start) begin
            chk1("start_while_busy", outstanding, 1'b0);
            chk1("start_on_empty", mq.size() == 0, 1'b0);
            if (mq.size() > 0 && !outstanding) begin
                chk("bu_op", 32'(bus.o_bu_op), 32'(mq[0].op));
                chk("bu_op1", bus.o_bu_op1, mq[0].op1);
                chk("bu_op2", bus.o_bu_op2, mq[0].op2);
                chk1("bu_pred", bus.o_bu_pred, mq[0].pred);
                outstanding = 1'b1;
                bu_dly      = 1 + (rnd_dly ? int'($urandom_range(3)) : extra);
                starts_q.push_back(cyc);
            end
            stall = 0;
        end else if (mq.size() > 0 && !outstanding) begin
            stall++;
            chk1("start_stall", stall > 1, 1'b0);
        end else begin
            stall = 0;
        end
    endtask

    task automatic drain();
        bit   a;
        int   n;
        ent_t z;
        z = '0;
        n = 0;
        while ((mq.size() > 0 || outstanding) && n < 300) begin
            cycle(1'b0, z, 1'b0, 1'b0, a);
            n++;
        end
        chk1("drain_timeout", n >= 300, 1'b0);
        repeat (2) cycle(1'b0, z, 1'b0, 1'b0, a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   a;
        int   n;
        int   k;
        ent_t z, e, e2, e3;
        z = '0;
        total = 0; bad = 0; cyc = 0; stall = 0; nres_dut = 0;
        outstanding = 1'b0; bu_dly = 0; extra = 0; rnd_dly = 1'b0;
        exp_rv = 1'b0; exp_fl = 1'b0; exp_tk = 1'b0; exp_mp = 1'b0; exp_rd = '0;
        rst_n = 1'b0; ext_flush = 1'b0;
        bus.i_enq_valid = 1'b0; bus.i_bu_valid = 1'b0;

        // Reset state
        repeat (2) cycle(1'b0, z, 1'b0, 1'b1, a);
        chk1("rst_enq_ready", bus.o_enq_ready, 1'b1);
        chk1("rst_bu_start", bus.o_bu_start, 1'b0);
        cycle(1'b0, z, 1'b0, 1'b0, a);

        // Correctly predicted beq, latency check
        e = '{op: 3'b000, op1: 32'd5, op2: 32'd5, pred: 1'b1, pc: 32'h100, target: 32'h200};
        cycle(1'b1, e, 1'b0, 1'b0, a);
        chk1("t1_accept", a, 1'b1);
        cycle(1'b0, z, 1'b0, 1'b0, a);
        chk1("t1_start_e1", bus.o_bu_start, 1'b1);
        cycle(1'b0, z, 1'b0, 1'b0, a);
        chk1("t1_start_e2", bus.o_bu_start, 1'b0);
        cycle(1'b0, z, 1'b0, 1'b0, a);
        chk1("t1_res_valid", bus.o_res_valid, 1'b1);
        chk1("t1_taken", bus.o_res_taken, 1'b1);
        chk1("t1_mispredict", bus.o_res_mispredict, 1'b0);
        chk("t1_redirect", bus.o_redirect_pc, 32'h200);
        chk1("t1_flush", bus.o_flush, 1'b0);
        cycle(1'b0, z, 1'b0, 1'b0, a);
        chk1("t1_res_pulse", bus.o_res_valid, 1'b0);
        drain();

        // Mispredicted bne discards the two younger branches
        e  = '{op: 3'b001, op1: 32'd3, op2: 32'd3, pred: 1'b1, pc: 32'h40, target: 32'h80};
        e2 = rnd_ent();
        e3 = rnd_ent();
        cycle(1'b1, e, 1'b0, 1'b0, a);
        cycle(1'b1, e2, 1'b0, 1'b0, a);
        cycle(1'b1, e3, 1'b0, 1'b0, a);
        cycle(1'b0, z, 1'b0, 1'b0, a);
        chk1("t2_res_valid", bus.o_res_valid, 1'b1);
        chk1("t2_flush", bus.o_flush, 1'b1);
        chk1("t2_mispredict", bus.o_res_mispredict, 1'b1);
        chk("t2_redirect", bus.o_redirect_pc, 32'h44);
        chk1("t2_ready", bus.o_enq_ready, 1'b1);
        n = 0;
        repeat (4) begin
            cycle(1'b0, z, 1'b0, 1'b0, a);
            n += int'(bus.o_bu_start);
        end
        chk("t2_no_start", 32'(n), 32'd0);
        drain();

        // Fill to DEPTH with enqueue held, pop while full
        extra = 6;
        repeat (14) begin
            bit pop_full;
            e = rnd_ent();
            e.pred = br_taken(e);
            pop_full = (mq.size() == DEPTH) && outstanding && (bu_dly == 0);
            if (mq.size() == DEPTH) chk1("t3_full_ready", bus.o_enq_ready, 1'b0);
            cycle(1'b1, e, 1'b0, 1'b0, a);
            if (pop_full) chk1("t3_ready_after_pop", bus.o_enq_ready, 1'b1);
        end
        extra = 0;
        drain();

        // Six good branches across pointer wrap: FIFO order and 2-cycle issue spacing
        starts_q.delete();
        nres_dut = 0;
        k = 0;
        n = 0;
        while (k < 6 && n < 50) begin
            e = rnd_ent();
            e.pred = br_taken(e);
            e.pc = 32'h1000 + 32'(k * 16);
            cycle(1'b1, e, 1'b0, 1'b0, a);
            if (a) k++;
            n++;
        end
        drain();
        chk("t4_nres", 32'(nres_dut), 32'd6);
        chk("t4_nstart", 32'(starts_q.size()), 32'd6);
        for (int i = 1; i < starts_q.size(); i++) begin
            chk("t4_spacing", 32'(starts_q[i] - starts_q[i-1]), 32'd2);
        end

        // External flush on the same edge as a mispredicting result
        e = rnd_ent();
        e.pred = !br_taken(e);
        cycle(1'b1, e, 1'b0, 1'b0, a);
        n = 0;
        while (!(outstanding && bu_dly == 0) && n < 20) begin
            cycle(1'b0, z, 1'b0, 1'b0, a);
            n++;
        end
        chk1("t5_wait_timeout", n < 20, 1'b1);
        cycle(1'b0, z, 1'b1, 1'b0, a);
        chk1("t5_no_res", bus.o_res_valid, 1'b0);
        chk1("t5_no_flush", bus.o_flush, 1'b0);
        chk1("t5_ready", bus.o_enq_ready, 1'b1);
        e2 = rnd_ent();
        cycle(1'b1, e2, 1'b0, 1'b0, a);
        chk1("t5_idle_no_start", bus.o_bu_start, 1'b0);
        cycle(1'b0, z, 1'b0, 1'b0, a);
        chk1("t5_idle_start", bus.o_bu_start, 1'b1);
        drain();

        // Reset in WAIT with three entries queued
        extra = 10;
        repeat (3) cycle(1'b1, rnd_ent(), 1'b0, 1'b0, a);
        cycle(1'b0, z, 1'b0, 1'b0, a);
        cycle(1'b0, z, 1'b0, 1'b1, a);
        chk1("t6_ready", bus.o_enq_ready, 1'b1);
        chk1("t6_start", bus.o_bu_start, 1'b0);
        chk1("t6_res_valid", bus.o_res_valid, 1'b0);
        cycle(1'b0, z, 1'b0, 1'b0, a);
        chk1("t6_no_start", bus.o_bu_start, 1'b0);
        extra = 0;

        // Random traffic with random branch-unit delay, flushes and resets
        rnd_dly = 1'b1;
        repeat (400) begin
            cycle(1'($urandom_range(1)), rnd_ent(), $urandom_range(31) == 0,
                  $urandom_range(199) == 0, a);
        end
        rnd_dly = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
